// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and hands each
// fetched instruction to decode through a registered IF/ID slot.
module instr_fetch #(
   parameter int unsigned        ADDR_W   = 16,
   parameter int unsigned        INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000,
   parameter logic [3:0]         HALT_OP  = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  im_addr,
   output logic               im_rd_en,
   input  logic [INSTR_W-1:0] im_instr,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [ADDR_W-1:0]  if_pc_plus1,
   output logic               if_valid,
   input  logic               id_ready,
   input  logic               flush,
   input  logic [ADDR_W-1:0]  flush_target,
   output logic               halted,
   output logic [1:0]         dbg_state
);

   // Handshake: decode takes if_instr on a rising edge where if_valid && id_ready.
   // The slot may be refilled on that same edge; while if_valid && !id_ready the
   // slot and the PC hold and no memory read is issued.

   typedef enum logic [1:0] {
      WAKE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              adv;
   logic              is_halt;

   assign adv       = !if_valid || id_ready;
   assign is_halt   = (im_instr[INSTR_W-1 -: 4] == HALT_OP);
   assign im_addr   = pc;
   assign im_rd_en  = (state == RUN) && adv;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAKE;
         pc          <= RESET_PC;
         if_instr    <= '0;
         if_pc       <= '0;
         if_pc_plus1 <= '0;
         if_valid    <= 1'b0;
         halted      <= 1'b0;
      end else if (flush) begin
         // Redirect beats stall and halt; the slot contents go stale under valid=0.
         state    <= RUN;
         pc       <= flush_target;
         if_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            WAKE: state <= RUN;
            RUN: begin
               if (adv) begin
                  if_instr    <= im_instr;
                  if_pc       <= pc;
                  if_pc_plus1 <= pc + 1'b1;
                  if_valid    <= 1'b1;
                  if (is_halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            HALTED: begin
               if (id_ready) if_valid <= 1'b0;
            end
            default: state <= WAKE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a transaction-level fetch model predicts
// every output each cycle, with literal checks on the directed scenarios.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_instr;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus1;
   logic        if_valid;
   logic        id_ready;
   logic        flush;
   logic [15:0] flush_target;
   logic        halted;
   logic [1:0]  dbg_state;

   logic [15:0] mem [0:65535];

   int n_vec  = 0;
   int n_fail = 0;

   // model: mode 0 = waking, 1 = fetching, 2 = stopped on halt
   int          m_mode;
   int          m_pc;
   int          m_valid;
   int          m_instr;
   int          m_ipc;
   int          m_ipc1;
   int          m_halted;

   always #5 clk = ~clk;

   assign im_instr = mem[im_addr];

   instr_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .im_addr      (im_addr),
      .im_rd_en     (im_rd_en),
      .im_instr     (im_instr),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pc_plus1  (if_pc_plus1),
      .if_valid     (if_valid),
      .id_ready     (id_ready),
      .flush        (flush),
      .flush_target (flush_target),
      .halted       (halted),
      .dbg_state    (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_pc     = 0;
      m_valid  = 0;
      m_instr  = 0;
      m_ipc    = 0;
      m_ipc1   = 0;
      m_halted = 0;
   endtask

   // What the stage must do on one rising edge, given the inputs held before it.
   task automatic model_step();
      int word;
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_pc     = int'(flush_target);
         m_valid  = 0;
         m_halted = 0;
         m_mode   = 1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         if (id_ready) m_valid = 0;
      end else if (m_valid == 0 || id_ready) begin
         word    = int'(mem[m_pc]);
         m_instr = word;
         m_ipc   = m_pc;
         m_ipc1  = (m_pc + 1) % 65536;
         m_valid = 1;
         if (word / 4096 == 15) begin
            m_mode   = 2;
            m_halted = 1;
         end else begin
            m_pc = (m_pc + 1) % 65536;
         end
      end
   endtask

   task automatic compare_all();
      int exp_rd;
      exp_rd = (m_mode == 1 && (m_valid == 0 || id_ready)) ? 1 : 0;
      check("im_addr",     32'(im_addr),     32'(m_pc));
      check("im_rd_en",    32'(im_rd_en),    32'(exp_rd));
      check("if_valid",    32'(if_valid),    32'(m_valid));
      check("halted",      32'(halted),      32'(m_halted));
      if (m_valid != 0) begin
         check("if_instr",    32'(if_instr),    32'(m_instr));
         check("if_pc",       32'(if_pc),       32'(m_ipc));
         check("if_pc_plus1", 32'(if_pc_plus1), 32'(m_ipc1));
      end
   endtask

   // Called just after a falling edge with the next inputs already set.
   task automatic tick();
      #1;
      compare_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_instr", 32'(if_instr), 32'd0);
      check("rst_if_pc",    32'(if_pc),    32'd0);
      check("rst_pc_plus1", 32'(if_pc_plus1), 32'd0);
      check("rst_halted",   32'(halted),   32'd0);
      check("rst_rd_en",    32'(im_rd_en), 32'd0);
      check("rst_im_addr",  32'(im_addr),  32'd0);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(0, 16'h7FFF) * 2 + $urandom_range(0, 1));
      mem[0]      = 16'h1111;
      mem[1]      = 16'h2222;
      mem[2]      = 16'h3333;
      mem[3]      = 16'h4444;
      mem[4]      = 16'h1234;
      mem[5]      = 16'hF000;
      mem[16'h40] = 16'h5A5A;
      mem[16'h41] = 16'h0041;
      mem[16'hFFFF] = 16'hABCD;
      id_ready     = 1'b1;
      flush        = 1'b0;
      flush_target = 16'h0000;
      rst_n        = 1'b0;
      model_reset();
      @(negedge clk);
      pulse_reset();

      // Wake cycle, then a back-to-back stream
      rst_n = 1'b1;
      #1;
      check("wake_rd_en", 32'(im_rd_en), 32'd0);
      tick();
      check("run_rd_en", 32'(im_rd_en), 32'd1);
      tick();
      check("first_instr", 32'(if_instr), 32'h1111);
      check("first_plus1", 32'(if_pc_plus1), 32'h0001);
      tick();
      check("second_instr", 32'(if_instr), 32'h2222);

      // Three stalled cycles hold everything
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", 32'(if_instr), 32'h2222);
         check("stall_addr",  32'(im_addr),  32'h0002);
         check("stall_rd_en", 32'(im_rd_en), 32'd0);
      end
      id_ready = 1'b1;
      tick();
      check("resume_instr", 32'(if_instr), 32'h3333);

      // Redirect: one bubble, then the target
      flush = 1'b1;
      flush_target = 16'h0040;
      tick();
      check("flush_bubble", 32'(if_valid), 32'd0);
      flush = 1'b0;
      tick();
      check("flush_pc",    32'(if_pc),    32'h0040);
      check("flush_instr", 32'(if_instr), 32'h5A5A);

      // Halt opcode delivered, fetch stops, flush restarts
      flush = 1'b1;
      flush_target = 16'h0005;
      tick();
      flush = 1'b0;
      tick();
      check("halt_instr", 32'(if_instr), 32'hF000);
      check("halt_pc",    32'(if_pc),    32'h0005);
      check("halt_flag",  32'(halted),   32'd1);
      check("halt_rd_en", 32'(im_rd_en), 32'd0);
      tick();
      check("halt_drain", 32'(if_valid), 32'd0);
      tick();
      check("halt_frozen", 32'(im_addr), 32'h0005);
      flush = 1'b1;
      flush_target = 16'h0000;
      tick();
      check("unhalt", 32'(halted), 32'd0);
      flush = 1'b0;
      tick();
      check("unhalt_instr", 32'(if_instr), 32'h1111);

      // PC wrap at the top of the address space
      flush = 1'b1;
      flush_target = 16'hFFFF;
      tick();
      flush = 1'b0;
      tick();
      check("wrap_instr", 32'(if_instr), 32'hABCD);
      check("wrap_plus1", 32'(if_pc_plus1), 32'h0000);
      tick();
      check("wrap_pc", 32'(if_pc), 32'h0000);

      // Reset while stalled on a live instruction
      id_ready = 1'b0;
      tick();
      check("pre_rst_valid", 32'(if_valid), 32'd1);
      pulse_reset();
      rst_n = 1'b1;
      id_ready = 1'b1;
      #1;
      check("rewake_rd_en", 32'(im_rd_en), 32'd0);
      tick();

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
            rst_n = 1'b1;
         end
         id_ready     = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 15) == 0);
         flush_target = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
